// File: rtl/opr_phase_sequencer.sv
// Per-instruction phase sequencer: issues ck1, stb1, ck2, stb2, ... until a decoder returns done.
// One-hot state register; every output is decoded from registered state only.
module opr_phase_sequencer #(
   parameter int NPHASES    = 6,
   parameter bit TIMEOUT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       step,
   input  logic       done,
   input  logic       clear_err,
   output logic       ck1,
   output logic       ck2,
   output logic       ck3,
   output logic       ck4,
   output logic       ck5,
   output logic       ck6,
   output logic       stb1,
   output logic       stb2,
   output logic       stb3,
   output logic       stb4,
   output logic       stb5,
   output logic       stb6,
   output logic [2:0] phase,
   output logic       busy,
   output logic       new_instr,
   output logic       err
);

   typedef enum logic [12:0] {
      StIdle = 13'h0001,
      StCk1  = 13'h0002,
      StStb1 = 13'h0004,
      StCk2  = 13'h0008,
      StStb2 = 13'h0010,
      StCk3  = 13'h0020,
      StStb3 = 13'h0040,
      StCk4  = 13'h0080,
      StStb4 = 13'h0100,
      StCk5  = 13'h0200,
      StStb5 = 13'h0400,
      StCk6  = 13'h0800,
      StStb6 = 13'h1000
   } state_e;

   // One-hot code of the final strobe; reaching it means no done was returned.
   localparam logic [12:0] LastStbHot = 13'(1) << (2 * NPHASES);

   state_e      state_q, state_d;
   state_e      end_state, timeout_state;
   logic [12:0] state_bits;
   logic        step_q;
   logic        err_q, err_d;
   logic        step_rise, start, timeout;
   logic [6:1]  ck_vec, stb_vec;

   assign step_rise = step & ~step_q;
   assign start     = ~err_q & (run | step_rise);
   assign timeout   = (state_q == LastStbHot);

   assign end_state     = (run && !err_q) ? StCk1 : StIdle;
   assign timeout_state = (!TIMEOUT_EN && run) ? StCk1 : StIdle;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StCk1;
         StCk1:  state_d = done ? end_state : StStb1;
         StStb1: state_d = (NPHASES > 1) ? StCk2 : timeout_state;
         StCk2:  state_d = done ? end_state : StStb2;
         StStb2: state_d = (NPHASES > 2) ? StCk3 : timeout_state;
         StCk3:  state_d = done ? end_state : StStb3;
         StStb3: state_d = (NPHASES > 3) ? StCk4 : timeout_state;
         StCk4:  state_d = done ? end_state : StStb4;
         StStb4: state_d = (NPHASES > 4) ? StCk5 : timeout_state;
         StCk5:  state_d = done ? end_state : StStb5;
         StStb5: state_d = (NPHASES > 5) ? StCk6 : timeout_state;
         StCk6:  state_d = done ? end_state : StStb6;
         StStb6: state_d = timeout_state;
         default: state_d = StIdle;
      endcase
   end

   // clear_err wins over a timeout landing in the same cycle.
   always_comb begin
      err_d = err_q;
      if (clear_err) begin
         err_d = 1'b0;
      end else if (TIMEOUT_EN && timeout) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         err_q   <= 1'b0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         step_q  <= step;
      end
   end

   assign state_bits = state_q;

   for (genvar n = 1; n <= 6; n++) begin : g_phase
      if (n <= NPHASES) begin : g_on
         assign ck_vec[n]  = state_bits[2*n-1];
         assign stb_vec[n] = state_bits[2*n];
      end else begin : g_off
         assign ck_vec[n]  = 1'b0;
         assign stb_vec[n] = 1'b0;
      end
   end

   always_comb begin
      phase = 3'd0;
      case (ck_vec | stb_vec)
         6'b000001: phase = 3'd1;
         6'b000010: phase = 3'd2;
         6'b000100: phase = 3'd3;
         6'b001000: phase = 3'd4;
         6'b010000: phase = 3'd5;
         6'b100000: phase = 3'd6;
         default:   phase = 3'd0;
      endcase
   end

   assign ck1  = ck_vec[1];
   assign ck2  = ck_vec[2];
   assign ck3  = ck_vec[3];
   assign ck4  = ck_vec[4];
   assign ck5  = ck_vec[5];
   assign ck6  = ck_vec[6];
   assign stb1 = stb_vec[1];
   assign stb2 = stb_vec[2];
   assign stb3 = stb_vec[3];
   assign stb4 = stb_vec[4];
   assign stb5 = stb_vec[5];
   assign stb6 = stb_vec[6];

   assign busy      = |state_bits[12:1];
   assign new_instr = state_bits[1];
   assign err       = err_q;

endmodule

// File: tb/tb_opr_phase_sequencer.sv
// Directed bench: instance 0 is 4-phase with timeout error, instance 1 is 6-phase wrapping.
module tb_opr_phase_sequencer;

   localparam int KI = 0;  // idle
   localparam int KC = 1;  // ck phase
   localparam int KS = 2;  // stb phase

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [1:0]      run, step, done, clear_err;
   logic [1:0][5:0] ck, stb;
   logic [1:0][2:0] phase;
   logic [1:0]      busy, new_instr, err;

   int total = 0;
   int bad   = 0;

   opr_phase_sequencer #(.NPHASES(4), .TIMEOUT_EN(1'b1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .run(run[0]), .step(step[0]), .done(done[0]),
      .clear_err(clear_err[0]),
      .ck1(ck[0][0]), .ck2(ck[0][1]), .ck3(ck[0][2]), .ck4(ck[0][3]), .ck5(ck[0][4]),
      .ck6(ck[0][5]),
      .stb1(stb[0][0]), .stb2(stb[0][1]), .stb3(stb[0][2]), .stb4(stb[0][3]),
      .stb5(stb[0][4]), .stb6(stb[0][5]),
      .phase(phase[0]), .busy(busy[0]), .new_instr(new_instr[0]), .err(err[0])
   );

   opr_phase_sequencer #(.NPHASES(6), .TIMEOUT_EN(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .run(run[1]), .step(step[1]), .done(done[1]),
      .clear_err(clear_err[1]),
      .ck1(ck[1][0]), .ck2(ck[1][1]), .ck3(ck[1][2]), .ck4(ck[1][3]), .ck5(ck[1][4]),
      .ck6(ck[1][5]),
      .stb1(stb[1][0]), .stb2(stb[1][1]), .stb3(stb[1][2]), .stb4(stb[1][3]),
      .stb5(stb[1][4]), .stb6(stb[1][5]),
      .phase(phase[1]), .busy(busy[1]), .new_instr(new_instr[1]), .err(err[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected outputs for instance d in state kind/n.
   task automatic expect_st(input string tag, input int d, input int kind, input int n,
                            input bit nw, input bit er);
      logic [5:0] eck, estb;
      eck  = (kind == KC) ? 6'(1 << (n - 1)) : 6'd0;
      estb = (kind == KS) ? 6'(1 << (n - 1)) : 6'd0;
      check_eq({tag, ".ck"}, 32'(ck[d]), 32'(eck));
      check_eq({tag, ".stb"}, 32'(stb[d]), 32'(estb));
      check_eq({tag, ".phase"}, 32'(phase[d]), (kind == KI) ? 32'd0 : 32'(n));
      check_eq({tag, ".busy"}, 32'(busy[d]), (kind == KI) ? 32'd0 : 32'd1);
      check_eq({tag, ".new"}, 32'(new_instr[d]), 32'(nw));
      check_eq({tag, ".err"}, 32'(err[d]), 32'(er));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; run = '0; step = '0; done = '0; clear_err = '0;
      #7;
      expect_st("reset_a", 0, KI, 0, 0, 0);
      expect_st("reset_b", 1, KI, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1; run[0] = 1'b1; done[0] = 1'b1;

      // Done at ck1 every time: back-to-back ck1.
      for (int i = 0; i < 4; i++) begin
         tick(); expect_st("t1_ck1", 0, KC, 1, 1, 0);
      end

      // Done at ck3.
      done[0] = 1'b0;
      tick(); expect_st("t2_stb1", 0, KS, 1, 0, 0);
      tick(); expect_st("t2_ck2", 0, KC, 2, 0, 0);
      tick(); expect_st("t2_stb2", 0, KS, 2, 0, 0);
      tick(); expect_st("t2_ck3", 0, KC, 3, 0, 0);
      done[0] = 1'b1;
      tick(); expect_st("t2_next", 0, KC, 1, 1, 0);
      run[0] = 1'b0;
      tick(); expect_st("t2_idle", 0, KI, 0, 0, 0);

      // Single step held for 4 cycles, done at ck2.
      done[0] = 1'b0; step[0] = 1'b1;
      tick(); expect_st("t3_ck1", 0, KC, 1, 1, 0);
      tick(); expect_st("t3_stb1", 0, KS, 1, 0, 0);
      tick(); expect_st("t3_ck2", 0, KC, 2, 0, 0);
      done[0] = 1'b1;
      tick(); expect_st("t3_idle", 0, KI, 0, 0, 0);
      step[0] = 1'b0; done[0] = 1'b0;
      tick(); expect_st("t3_hold1", 0, KI, 0, 0, 0);
      tick(); expect_st("t3_hold2", 0, KI, 0, 0, 0);

      // Timeout on 4-phase instance.
      run[0] = 1'b1;
      tick(); expect_st("t4_ck", 0, KC, 1, 1, 0);
      for (int n = 1; n <= 4; n++) begin
         tick(); expect_st("t4_stb", 0, KS, n, 0, 0);
         if (n < 4) begin
            tick(); expect_st("t4_ck", 0, KC, n + 1, 0, 0);
         end
      end
      tick(); expect_st("t4_err", 0, KI, 0, 0, 1);
      tick(); expect_st("t4_block1", 0, KI, 0, 0, 1);
      tick(); expect_st("t4_block2", 0, KI, 0, 0, 1);
      clear_err[0] = 1'b1;
      tick(); expect_st("t4_clear", 0, KI, 0, 0, 0);
      clear_err[0] = 1'b0;
      tick(); expect_st("t4_restart", 0, KC, 1, 1, 0);

      // Asynchronous reset during stb2.
      tick(); expect_st("t5_stb1", 0, KS, 1, 0, 0);
      tick(); expect_st("t5_ck2", 0, KC, 2, 0, 0);
      tick(); expect_st("t5_stb2", 0, KS, 2, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      expect_st("t5_rst", 0, KI, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(); expect_st("t5_ck1", 0, KC, 1, 1, 0);

      // run dropped at ck2, done at ck4, done pulses in stb ignored.
      tick(); expect_st("t6_stb1", 0, KS, 1, 0, 0);
      tick(); expect_st("t6_ck2", 0, KC, 2, 0, 0);
      run[0] = 1'b0;
      tick(); expect_st("t6_stb2", 0, KS, 2, 0, 0);
      done[0] = 1'b1;
      tick(); expect_st("t6_ck3", 0, KC, 3, 0, 0);
      done[0] = 1'b0;
      tick(); expect_st("t6_stb3", 0, KS, 3, 0, 0);
      done[0] = 1'b1;
      tick(); expect_st("t6_ck4", 0, KC, 4, 0, 0);
      tick(); expect_st("t6_idle", 0, KI, 0, 0, 0);
      done[0] = 1'b0;

      // clear_err coincident with timeout keeps err low.
      run[0] = 1'b1;
      tick(); expect_st("t7_ck1", 0, KC, 1, 1, 0);
      for (int i = 0; i < 7; i++) tick();
      expect_st("t7_stb4", 0, KS, 4, 0, 0);
      clear_err[0] = 1'b1;
      tick(); expect_st("t7_noerr", 0, KI, 0, 0, 0);
      clear_err[0] = 1'b0;
      tick(); expect_st("t7_restart", 0, KC, 1, 1, 0);
      run[0] = 1'b0; done[0] = 1'b1;
      tick(); expect_st("t7_idle", 0, KI, 0, 0, 0);
      done[0] = 1'b0;

      // 6-phase, timeout disabled: wraps to ck1 with run high.
      run[1] = 1'b1;
      tick(); expect_st("t8_ck", 1, KC, 1, 1, 0);
      for (int n = 1; n <= 6; n++) begin
         tick(); expect_st("t8_stb", 1, KS, n, 0, 0);
         if (n < 6) begin
            tick(); expect_st("t8_ck", 1, KC, n + 1, 0, 0);
         end
      end
      tick(); expect_st("t8_wrap", 1, KC, 1, 1, 0);
      run[1] = 1'b0; done[1] = 1'b1;
      tick(); expect_st("t8_idle", 1, KI, 0, 0, 0);
      expect_st("t8_a_idle", 0, KI, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/opr_phase_sequencer.md
Name: opr_phase_sequencer

Overview:
- Generates the per-instruction phase timing that the instruction decoders consume.
- Outputs one-cycle phase pulses ck1..ck6 and strobes stb1..stb6 in strict alternation: ck1, stb1, ck2, stb2, ...
- Terminates the instruction when a decoder returns done, then starts the next instruction or idles.
- Sits between the run/step front-panel control and the OPR/memory-reference instruction decoders.

Parameters:
NPHASES, 6, last phase the sequencer may issue (legal range 2..6); ckN/stbN for N > NPHASES are tied 0.
TIMEOUT_EN, 1, 1 = missing done past stb(NPHASES) raises err; 0 = silently wraps to the next instruction.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst_n  in  1  asynchronous active-low reset.
run  in  1  level; 1 = free-run instructions back to back.
step  in  1  rising-edge sensitive; starts exactly one instruction when idle and run=0.
done  in  1  instruction complete; sampled only while a ck phase is active.
clear_err  in  1  synchronous; clears err.
ck1..ck6  out  1 each  phase clock pulses; one clk cycle wide.
stb1..stb6  out  1 each  phase strobes; one clk cycle wide.
phase  out  3  current phase number 1..6; 0 when idle.
busy  out  1  1 while an instruction is in progress.
new_instr  out  1  one-cycle pulse coincident with ck1 of every instruction.
err  out  1  sticky timeout flag.

Behaviour:
- State encoding and outputs:
  - States: IDLE, CKn, STBn for n = 1..NPHASES.
  - State register is one-hot. All outputs are decoded from registered state, with no combinational path from inputs to outputs.
  - At most one ck/stb output is high per cycle.
- Reset (rst_n=0, asynchronous): state IDLE; all ck/stb, phase, busy, new_instr and err = 0; step edge detector cleared.
- IDLE transitions:
  - To CK1 if err=0 and (run=1 or a step rising edge is detected). new_instr=1 in that CK1 cycle.
  - Otherwise remain in IDLE.
- CKn transitions:
  - If done=1, the instruction ends and STBn is not issued.
    - Next state is CK1 if run=1 and err=0.
    - Otherwise next state is IDLE. Step-started instructions always return to IDLE unless run has risen.
  - If done=0, next state is STBn.
- STBn transitions (n < NPHASES): next state is CK(n+1). done is ignored in STB states.
- STB(NPHASES) with no done seen (timeout):
  - TIMEOUT_EN=1: err set, next state IDLE regardless of run.
  - TIMEOUT_EN=0: next state CK1 if run=1, else IDLE.
- Latency:
  - An instruction with done at ckK occupies 2K-1 clk cycles.
  - The next ck1 follows in the very next cycle; there are no gap cycles while run=1.
- run deasserted mid-instruction: the current instruction completes normally, then the sequencer enters IDLE.
- Step handling:
  - Step edges arriving while busy or while run=1 are discarded, not queued.
  - Holding step high starts only one instruction.
- Error handling:
  - clear_err=1 clears err on the next edge; it has priority over a same-cycle err set.
  - Start is blocked while err=1.
- Status outputs:
  - busy=1 in every CK/STB state.
  - phase = n in CKn and STBn.

Test Plan:
1. Reset, then run=1 with done asserted at ck1 each time -> ck1 pulses every cycle, new_instr every cycle, no stb1, phase=1 constant.
2. run=1, done at ck3 -> sequence ck1,stb1,ck2,stb2,ck3 (5 cycles), then ck1 next cycle; phase 1,1,2,2,3.
3. run=0, step pulse held 4 cycles, done at ck2 -> exactly one instruction (ck1,stb1,ck2), then IDLE with busy=0 and phase=0; no second start.
4. TIMEOUT_EN=1, NPHASES=4, done never asserted -> ck1..stb4 (8 cycles), err=1, IDLE; run still 1 but no restart until clear_err pulse, then ck1 next cycle.
5. rst_n dropped during stb2 -> all outputs 0 immediately (asynchronous); after release with run=1, ck1 with new_instr on first edge.
6. run dropped during ck2 of a 4-phase instruction (done at ck4) -> instruction finishes through ck4, then IDLE; done pulses in stb states ignored.
